// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between requesters A and B,
// with a clear-then-guard flush sequence that blocks grants while active.
module fifo_push_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ack_b,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  input  logic                  fifo_full,
  output logic                  fifo_enQ,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_clear,
  output logic [CNT_WIDTH-1:0]  push_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;   // 0: A has priority, 1: B
  logic [HW-1:0]         hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  push_count_q, push_count_d;

  logic grant_ok, gnt_a, gnt_b;

  // flush_req outranks any pending request in the same cycle
  assign grant_ok = !reset && (state_q == IDLE) && !flush_req && !fifo_full;
  assign gnt_a    = grant_ok && req_a && (!req_b || !prio_q);
  assign gnt_b    = grant_ok && req_b && (!req_a ||  prio_q);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    hold_d       = hold_q;
    push_count_d = push_count_q;
    if (gnt_a) prio_d = 1'b1;
    if (gnt_b) prio_d = 1'b0;
    if (gnt_a || gnt_b) push_count_d = push_count_q + CNT_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      hold_q       <= '0;
      push_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      hold_q       <= hold_d;
      push_count_q <= push_count_d;
    end
  end

  // Everything is forced low while reset is held, including state-derived flags
  assign ack_a      = gnt_a;
  assign ack_b      = gnt_b;
  assign fifo_enQ   = gnt_a || gnt_b;
  assign fifo_data  = gnt_a ? data_a : (gnt_b ? data_b : '0);
  assign fifo_clear = !reset && (state_q == FLUSH);
  assign flush_busy = !reset && (state_q != IDLE);
  assign flush_done = !reset && (state_q == HOLD) && (hold_q == HOLD_LAST);
  assign push_count = reset ? '0 : push_count_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: expected pushes go into a scoreboard queue, a negedge monitor
// pops and compares whenever the arbiter writes the FIFO.
module tb_fifo_push_arbiter;

  logic       clock;
  logic       reset;
  logic       req_a, req_b, flush_req, fifo_full;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, flush_busy, flush_done, fifo_enQ, fifo_clear;
  logic [7:0] fifo_data;
  logic [3:0] push_count;

  typedef struct packed {
    logic       is_b;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b1;

  fifo_push_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .fifo_full(fifo_full), .fifo_enQ(fifo_enQ), .fifo_data(fifo_data),
    .fifo_clear(fifo_clear), .push_count(push_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_push(input logic is_b, input logic [7:0] d);
    exp_t e;
    e.is_b = is_b;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pops on every FIFO write, plus per-cycle grant invariants
  always @(negedge clock) begin
    if (mon_en) begin
      if (fifo_enQ) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_push", {ack_b, ack_a, fifo_data}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("push", {22'h0, ack_b, ack_a, fifo_data}, {22'h0, e.is_b, !e.is_b, e.d});
        end
        chk("enq_while_full", {31'h0, fifo_full}, 32'h0);
      end else begin
        chk("idle_port", {22'h0, ack_b, ack_a, fifo_data}, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1; flush_req = 1'b0; fifo_full = 1'b0;
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22;

    // T1: reset held with both requests high
    repeat (3) begin
      step();
      #2 chk("reset_outputs",
             {ack_a, ack_b, flush_busy, flush_done, fifo_enQ, fifo_clear, fifo_data, push_count},
             32'h0);
    end

    // T2: contention; first grant after reset goes to A, then alternates
    step();
    reset = 1'b0;
    expect_push(1'b0, 8'h11);
    for (int i = 1; i < 6; i++) begin
      step();
      expect_push(i[0], i[0] ? 8'h22 : 8'h11);
    end
    step();
    req_a = 1'b0; req_b = 1'b0;
    #2 chk("count_after_contention", {28'h0, push_count}, 32'd6);

    // T3: full backpressure
    fifo_full = 1'b1; req_a = 1'b1; data_a = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #2 chk("full_blocks", {30'h0, fifo_enQ, ack_a}, 32'h0);
      step();
    end
    fifo_full = 1'b0;
    expect_push(1'b0, 8'h5A);
    step();
    req_a = 1'b0;
    #2 chk("count_after_full", {28'h0, push_count}, 32'd7);

    // T4: flush colliding with a request from B
    step();
    flush_req = 1'b1; req_b = 1'b1; data_b = 8'h3C;
    #2 chk("flush_wins", {30'h0, ack_b, fifo_enQ}, 32'h0);
    step();
    flush_req = 1'b0;
    #2 chk("flush_state", {29'h0, fifo_clear, flush_busy, ack_b}, 32'h6);
    for (int k = 0; k < 4; k++) begin
      step();
      flush_req = (k == 1);
      #2 chk("hold_state", {28'h0, fifo_clear, flush_busy, flush_done, ack_b},
             {28'h0, 1'b0, 1'b1, (k == 3), 1'b0});
    end
    step();
    flush_req = 1'b0;
    expect_push(1'b1, 8'h3C);
    #2 chk("post_hold_idle", {30'h0, flush_busy, flush_done}, 32'h0);
    step();
    req_b = 1'b0;
    #2 chk("count_after_flush", {28'h0, push_count}, 32'd8);

    // T5: reset during HOLD
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    #2 chk("reset_in_hold", {29'h0, flush_busy, flush_done, fifo_clear}, 32'h0);
    step();
    reset = 1'b0; req_a = 1'b1; data_a = 8'h77;
    expect_push(1'b0, 8'h77);
    #2 chk("after_hold_reset", {25'h0, flush_busy, fifo_clear, flush_done, push_count}, 32'h0);
    step();
    req_a = 1'b0;
    #2 chk("count_after_reset", {28'h0, push_count}, 32'd1);
    repeat (4) begin
      step();
      chk("no_flush_done", {31'h0, flush_done}, 32'h0);
    end

    // T6: 4-bit counter wrap after 17 pushes
    reset = 1'b1;
    step();
    reset = 1'b0; req_a = 1'b1; req_b = 1'b1; data_a = 8'hA5; data_b = 8'hB6;
    for (int i = 0; i < 17; i++) begin
      expect_push(i[0], i[0] ? 8'hB6 : 8'hA5);
      if (i == 16) #2 chk("count_at_16", {28'h0, push_count}, 32'd0);
      step();
    end
    req_a = 1'b0; req_b = 1'b0;
    #2 chk("count_wrap", {28'h0, push_count}, 32'd1);

    repeat (3) step();
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
